// File: rtl/rv32_pkg.sv
// Shared RV32I constants: datapath width, ALU opcodes and funct3 operation codes.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } funct3_e;

  // OP and OP-IMM differ only in bit 5, so one mask covers both.
  function automatic logic opc_is_alu(input logic [6:0] opcode);
    return (opcode[6] == 1'b0) && (opcode[4:0] == 5'b10011);
  endfunction

endpackage

// File: rtl/rv32_shifter.sv
// Combinational barrel shifter. dir=1 shifts right (arith selects sign fill),
// dir=0 shifts left by reusing the right shifter on a bit-reversed operand.
module rv32_shifter #(
  parameter int XLEN = rv32_pkg::XLEN,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] value,
  input  logic [SHW-1:0]  shamt,
  input  logic            dir,
  input  logic            arith,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] value_rev;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] shifted_rev;
  logic            fill_ones;

  for (genvar gi = 0; gi < XLEN; gi++) begin : g_rev
    assign value_rev[gi]   = value[XLEN-1-gi];
    assign shifted_rev[gi] = shifted[XLEN-1-gi];
  end

  assign operand   = dir ? value : value_rev;
  assign fill_ones = dir & arith & operand[XLEN-1];
  // Shifting the complement in zeros and complementing back fills with ones.
  assign shifted   = fill_ones ? ~((~operand) >> shamt) : (operand >> shamt);
  assign result    = dir ? shifted : shifted_rev;

endmodule

// File: rtl/rv32_alu.sv
// RV32I integer ALU for OP / OP-IMM instructions with a one-cycle registered
// result and a compute-complete flag.
module rv32_alu #(
  parameter int XLEN = rv32_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      funct3,
  input  logic            modbit,
  input  logic [XLEN-1:0] imm,
  input  logic [6:0]      opcode,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] rd,
  output logic            comp
);
  import rv32_pkg::*;

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] b;
  logic [XLEN-1:0] shift_result;
  logic [XLEN-1:0] result_next;
  logic            valid;
  logic            is_sub;
  logic [XLEN-1:0] rd_reg;
  logic            comp_reg;

  assign valid  = opc_is_alu(opcode);
  assign b      = opcode[5] ? rs2 : imm;
  // OP-IMM has no SUBI; bit 30 there is just immediate bits.
  assign is_sub = opcode[5] & modbit;

  rv32_shifter #(.XLEN(XLEN), .SHW(SHW)) u_shifter (
    .value  (rs1),
    .shamt  (b[SHW-1:0]),
    .dir    (funct3 == F3_SR),
    .arith  (modbit),
    .result (shift_result)
  );

  always_comb begin
    result_next = '0;
    case (funct3_e'(funct3))
      F3_ADD:  result_next = is_sub ? (rs1 - b) : (rs1 + b);
      F3_SLL:  result_next = shift_result;
      F3_SLT:  result_next = {{(XLEN-1){1'b0}}, ($signed(rs1) < $signed(b))};
      F3_SLTU: result_next = {{(XLEN-1){1'b0}}, (rs1 < b)};
      F3_XOR:  result_next = rs1 ^ b;
      F3_SR:   result_next = shift_result;
      F3_OR:   result_next = rs1 | b;
      F3_AND:  result_next = rs1 & b;
      default: result_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_reg   <= '0;
      comp_reg <= 1'b0;
    end else begin
      comp_reg <= valid;
      if (valid) begin
        rd_reg <= result_next;
      end
    end
  end

  assign rd   = rd_reg;
  assign comp = comp_reg;

endmodule

// File: tb/tb_rv32_alu.sv
// Self-checking bench for rv32_alu: directed vector table, reset corners, and
// randomized ops checked against an arithmetic reference model.
module tb_rv32_alu;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  funct3;
  logic        modbit;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] rd;
  logic        comp;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        mb;
    logic [31:0] a;
    logic [31:0] r2;
    logic [31:0] im;
    logic [31:0] exp_rd;
    logic        exp_comp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  rv32_alu dut (
    .clk    (clk),
    .reset  (reset),
    .funct3 (funct3),
    .modbit (modbit),
    .imm    (imm),
    .opcode (opcode),
    .rs1    (rs1),
    .rs2    (rs2),
    .rd     (rd),
    .comp   (comp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [6:0] o, input logic [2:0] f, input logic m,
                         input logic [31:0] a, input logic [31:0] r2, input logic [31:0] im,
                         input logic [31:0] er, input logic ec);
    vec_t v;
    v.opc = o; v.f3 = f; v.mb = m; v.a = a; v.r2 = r2; v.im = im;
    v.exp_rd = er; v.exp_comp = ec;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f, input logic m,
                       input logic [31:0] a, input logic [31:0] r2, input logic [31:0] im);
    opcode = o; funct3 = f; modbit = m; rs1 = a; rs2 = r2; imm = im;
  endtask

  // Reference model: straight from the ISA rules.
  function automatic void ref_alu(input logic [6:0] o, input logic [2:0] f, input logic m,
                                  input logic [31:0] a, input logic [31:0] r2,
                                  input logic [31:0] im, output logic valid,
                                  output logic [31:0] res);
    logic [31:0] b;
    int unsigned sh;
    valid = (o == OP) || (o == IMM);
    b     = (o == OP) ? r2 : im;
    sh    = b % 32;
    case (f)
      3'd0:    res = (o == OP && m) ? a - b : a + b;
      3'd1:    res = a << sh;
      3'd2:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    res = (a < b) ? 32'd1 : 32'd0;
      3'd4:    res = a ^ b;
      3'd5:    res = m ? 32'($signed(a) >>> sh) : (a >> sh);
      3'd6:    res = a | b;
      default: res = a & b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corner [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1F};
    if ($urandom_range(3) == 0) return corner[$urandom_range(5)];
    return $urandom;
  endfunction

  initial begin
    logic [31:0] exp_rd;
    logic [31:0] res;
    logic        v_ok;
    logic [6:0]  o;

    // OP entries carry a junk imm, OP-IMM entries a junk rs2, to catch operand-select errors.
    add_vec(OP,  3'd0, 1'b0, 32'd5,        32'd7,        32'hDEAD0000, 32'd12,       1'b1);
    add_vec(OP,  3'd0, 1'b1, 32'd0,        32'd1,        32'hDEAD0000, 32'hFFFFFFFF, 1'b1);
    add_vec(IMM, 3'd0, 1'b1, 32'd10,       32'h00000055, 32'hFFFFFFFE, 32'd8,        1'b1);
    add_vec(IMM, 3'd5, 1'b1, 32'h80000000, 32'h00000001, 32'd4,        32'hF8000000, 1'b1);
    add_vec(IMM, 3'd5, 1'b0, 32'h80000000, 32'h00000001, 32'd4,        32'h08000000, 1'b1);
    add_vec(OP,  3'd1, 1'b0, 32'd1,        32'h21,       32'h5,        32'd2,        1'b1);
    add_vec(OP,  3'd2, 1'b0, 32'hFFFFFFFF, 32'd1,        32'h0,        32'd1,        1'b1);
    add_vec(OP,  3'd3, 1'b0, 32'hFFFFFFFF, 32'd1,        32'h0,        32'd0,        1'b1);
    add_vec(IMM, 3'd2, 1'b0, 32'd3,        32'd9,        32'd3,        32'd0,        1'b1);
    add_vec(OP,  3'd4, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        32'hFF00FF00, 1'b1);
    add_vec(OP,  3'd6, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        32'hFFF0FFF0, 1'b1);
    add_vec(OP,  3'd7, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        32'h00F000F0, 1'b1);
    add_vec(OP,  3'd5, 1'b1, 32'h80000001, 32'h20,       32'h3,        32'h80000001, 1'b1);
    add_vec(IMM, 3'd0, 1'b0, 32'h1230,     32'h0,        32'd4,        32'h1234,     1'b1);
    add_vec(7'b0000011, 3'd0, 1'b0, 32'd1, 32'd1,        32'd1,        32'h1234,     1'b0);
    add_vec(7'b1110011, 3'd0, 1'b0, 32'd1, 32'd1,        32'd1,        32'h1234,     1'b0);
    add_vec(IMM, 3'd3, 1'b0, 32'd2,        32'd0,        32'hFFFFFFFF, 32'd1,        1'b1);

    // Reset with a valid ADD presented.
    reset = 1'b1;
    drive(OP, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset: rd=%h comp=%0b", rd, comp);
    check("reset_rd", rd, 32'd0);
    check("reset_comp", {31'd0, comp}, 32'd0);

    // Table: consecutive cycles, so this also exercises back-to-back issue.
    @(negedge clk);
    reset = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i].opc, vecs[i].f3, vecs[i].mb, vecs[i].a, vecs[i].r2, vecs[i].im);
      @(posedge clk);
      #1;
      $display("[TB] vec %0d: opc=%b f3=%0d mb=%0b rd=%h comp=%0b", i, vecs[i].opc,
               vecs[i].f3, vecs[i].mb, rd, comp);
      check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_comp", i), {31'd0, comp}, {31'd0, vecs[i].exp_comp});
      @(negedge clk);
    end

    // Mid-run reset must override a valid op and clear a non-zero rd.
    reset = 1'b1;
    drive(OP, 3'd6, 1'b0, 32'hFFFF0000, 32'h0000FFFF, 32'd0);
    @(posedge clk);
    #1;
    $display("[TB] midreset: rd=%h comp=%0b", rd, comp);
    check("midreset_rd", rd, 32'd0);
    check("midreset_comp", {31'd0, comp}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized back-to-back ops against the reference model.
    exp_rd = 32'd0;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(4))
        0:       o = 7'($urandom);
        1, 2:    o = OP;
        default: o = IMM;
      endcase
      drive(o, 3'($urandom), 1'($urandom), pick(), pick(), pick());
      ref_alu(opcode, funct3, modbit, rs1, rs2, imm, v_ok, res);
      if (v_ok) exp_rd = res;
      @(posedge clk);
      #1;
      $display("[TB] rnd %0d: opc=%b f3=%0d mb=%0b rs1=%h rs2=%h imm=%h rd=%h comp=%0b",
               n, opcode, funct3, modbit, rs1, rs2, imm, rd, comp);
      check($sformatf("rnd%0d_rd", n), rd, exp_rd);
      check($sformatf("rnd%0d_comp", n), {31'd0, comp}, {31'd0, v_ok});
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv32_alu.md
Name: rv32_alu

Overview:
- Integer ALU for the RV32I core; executes the register-register (OP, opcode 0110011) and register-immediate (OP-IMM, opcode 0010011) arithmetic/logic instructions.
- Sits beside the core's execute stage. The core presents decoded fields and operands, then writes rd into the register file the cycle after the ALU edge.
- Result is registered: one clock of latency.

Parameters:
- XLEN, 32, datapath width (only 32 is required to be supported)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- funct3  input  3  instruction bits [14:12], selects the operation
- modbit  input  1  instruction bit [30]; selects SUB vs ADD and SRA vs SRL
- imm  input  32  sign-extended I-type immediate
- opcode  input  7  instruction bits [6:0]
- rs1  input  32  source operand 1 value
- rs2  input  32  source operand 2 value
- rd  output  32  registered result
- comp  output  1  registered "compute complete" flag

Behaviour:
- Reset (reset=1 at a clk edge): rd=0, comp=0. Reset overrides any operation presented in the same cycle.
- Valid opcodes: opcode matches 0x10011, where bit 5 selects the second operand:
  - bit5=1 (OP): b = rs2
  - bit5=0 (OP-IMM): b = imm
- On each clk edge, if the opcode is valid: rd <= f(funct3, modbit, rs1, b) and comp <= 1.
- On each clk edge, if the opcode is not valid: rd holds its value and comp <= 0.
- comp is therefore high for exactly the cycles following a valid-opcode edge.
- Operations by funct3:
  - 000 ADD/SUB: OP with modbit=1 gives rs1-b; otherwise rs1+b. For OP-IMM, modbit is ignored and the result is always ADDI. Wrap modulo 2^32, no overflow flag.
  - 001 SLL: rs1 << b[4:0].
  - 010 SLT: result 1 if signed(rs1) < signed(b), else 0 (zero-extended).
  - 011 SLTU: result 1 if unsigned(rs1) < unsigned(b), else 0.
  - 100 XOR: rs1 ^ b.
  - 101 SRL/SRA: modbit=1 gives arithmetic right shift (sign fill); modbit=0 gives logical right shift. Shift amount is b[4:0], and this applies to both OP and OP-IMM.
  - 110 OR: rs1 | b.
  - 111 AND: rs1 & b.
- Shift amounts use only the low 5 bits; upper bits of b are ignored (shift by 32 acts as shift by 0).
- The ALU has no knowledge of rd index 0; suppressing writes to x0 is the core's responsibility.
- Inputs are sampled only at the clk edge. Inputs changing between edges have no effect.
- Back-to-back operations are allowed, one per cycle, with no stall.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode constants OPC_OP=0110011 and OPC_OP_IMM=0010011
  - funct3 constants F3_ADD, F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SR, F3_OR, F3_AND
  - XLEN
- One optional sub-module, rv32_shifter: combinational 32-bit barrel shifter with inputs value, shamt[4:0], dir, arith.
- All remaining logic stays in rv32_alu: a combinational result mux feeding the output registers.

Test Plan:
- Reset: hold reset=1 with a valid ADD presented -> rd=0, comp=0. Release reset, present opcode=0110011, funct3=000, modbit=0, rs1=5, rs2=7 -> after one edge rd=12, comp=1.
- SUB wrap: OP, modbit=1, rs1=0, rs2=1 -> rd=0xFFFFFFFF. Then OP-IMM, funct3=000, modbit=1, rs1=10, imm=0xFFFFFFFE -> rd=8 (ADDI, modbit ignored).
- Shifts:
  - rs1=0x80000000, OP-IMM, imm=4, funct3=101, modbit=1 -> rd=0xF8000000
  - same with modbit=0 -> rd=0x08000000
  - SLL with rs2=0x21, rs1=1 -> rd=2 (only shamt[4:0]=1 used)
- Compares:
  - SLT, rs1=0xFFFFFFFF, rs2=1 -> rd=1
  - SLTU, same operands -> rd=0
  - SLTI, rs1=3, imm=3 -> rd=0
- Logic: rs1=0xF0F0F0F0, rs2=0x0FF00FF0 -> XOR rd=0xFF00FF00, OR rd=0xFFF0FFF0, AND rd=0x00F000F0.
- Invalid opcode: after a valid op leaving rd=0x1234, present opcode=0000011 -> rd stays 0x1234 and comp goes 0 on the next edge. Back-to-back valid ops on consecutive cycles -> each result appears one cycle later, with comp held at 1.
